mem_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the single-port synchronous memory (16-bit data, 9-bit address, valid/ready handshake, write when `wr_rd=1`). It sits between two bus masters (A, B) and the memory. It serialises their transactions, drives exactly one memory access at a time, returns read data and completion to the granted master, and flags memory accesses that never complete.

---
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer placing two bus masters on one
// single-port memory, with a per-access timeout and sticky flag.
module mem_arbiter #(
  parameter int W   = 16,
  parameter int AD  = 9,
  parameter int TMO = 15
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [AD-1:0] a_addr_i,
  input  logic [W-1:0]  a_wdata_i,
  input  logic          a_wr_rd_i,
  input  logic          a_valid_i,
  output logic          a_ready_o,
  output logic [W-1:0]  a_rdata_o,
  output logic          a_err_o,
  input  logic [AD-1:0] b_addr_i,
  input  logic [W-1:0]  b_wdata_i,
  input  logic          b_wr_rd_i,
  input  logic          b_valid_i,
  output logic          b_ready_o,
  output logic [W-1:0]  b_rdata_o,
  output logic          b_err_o,
  output logic [AD-1:0] mem_addr_o,
  output logic [W-1:0]  mem_write_o,
  output logic          mem_wr_rd_o,
  output logic          mem_valid_o,
  input  logic          mem_ready_i,
  input  logic [W-1:0]  mem_read_i,
  output logic          timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [7:0] TMO_C = 8'(TMO);

  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          gnt_q, gnt_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [AD-1:0] maddr_d;
  logic [W-1:0]  mwdata_d;
  logic          mwr_d, mvalid_d;
  logic          ardy_d, brdy_d;
  logic          aerr_d, berr_d;
  logic [W-1:0]  ardata_d, brdata_d;
  logic          tmo_d;
  logic          pick_b;

  // ptr_q = 1 means B holds priority on a tie
  assign pick_b = b_valid_i & (~a_valid_i | ptr_q);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    maddr_d  = mem_addr_o;
    mwdata_d = mem_write_o;
    mwr_d    = mem_wr_rd_o;
    mvalid_d = mem_valid_o;
    ardy_d   = a_ready_o;
    brdy_d   = b_ready_o;
    aerr_d   = a_err_o;
    berr_d   = b_err_o;
    ardata_d = a_rdata_o;
    brdata_d = b_rdata_o;
    tmo_d    = timeout_o;
    unique case (state_q)
      S_IDLE: begin
        if (a_valid_i | b_valid_i) begin
          gnt_d    = pick_b;
          ptr_d    = ~pick_b;
          maddr_d  = pick_b ? b_addr_i : a_addr_i;
          mwdata_d = pick_b ? b_wdata_i : a_wdata_i;
          mwr_d    = pick_b ? b_wr_rd_i : a_wr_rd_i;
          mvalid_d = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mvalid_d = 1'b0;
        cnt_d    = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ready_i) begin
          if (!mem_wr_rd_o) begin
            if (gnt_q) brdata_d = mem_read_i;
            else       ardata_d = mem_read_i;
          end
          ardy_d  = ~gnt_q;
          brdy_d  = gnt_q;
          state_d = S_RESP;
        end else if (cnt_q == TMO_C) begin
          if (gnt_q) brdata_d = '0;
          else       ardata_d = '0;
          ardy_d  = ~gnt_q;
          brdy_d  = gnt_q;
          aerr_d  = ~gnt_q;
          berr_d  = gnt_q;
          tmo_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        ardy_d  = 1'b0;
        brdy_d  = 1'b0;
        aerr_d  = 1'b0;
        berr_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      ptr_q       <= 1'b0;
      gnt_q       <= 1'b0;
      cnt_q       <= '0;
      mem_addr_o  <= '0;
      mem_write_o <= '0;
      mem_wr_rd_o <= 1'b0;
      mem_valid_o <= 1'b0;
      a_ready_o   <= 1'b0;
      b_ready_o   <= 1'b0;
      a_err_o     <= 1'b0;
      b_err_o     <= 1'b0;
      a_rdata_o   <= '0;
      b_rdata_o   <= '0;
      timeout_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      mem_addr_o  <= maddr_d;
      mem_write_o <= mwdata_d;
      mem_wr_rd_o <= mwr_d;
      mem_valid_o <= mvalid_d;
      a_ready_o   <= ardy_d;
      b_ready_o   <= brdy_d;
      a_err_o     <= aerr_d;
      b_err_o     <= berr_d;
      a_rdata_o   <= ardata_d;
      b_rdata_o   <= brdata_d;
      timeout_o   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: memory model with stall control,
// pulse monitors, and hand-computed expectations.
module tb_mem_arbiter;
  localparam int W   = 16;
  localparam int AD  = 9;
  localparam int TMO = 15;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [AD-1:0] a_addr_i, b_addr_i, mem_addr_o;
  logic [W-1:0]  a_wdata_i, b_wdata_i;
  logic          a_wr_rd_i, b_wr_rd_i, a_valid_i, b_valid_i;
  logic          a_ready_o, b_ready_o, a_err_o, b_err_o;
  logic [W-1:0]  a_rdata_o, b_rdata_o, mem_write_o, mem_read_i;
  logic          mem_wr_rd_o, mem_valid_o, mem_ready_i, timeout_o;

  int   n_cmp = 0;
  int   n_err = 0;
  int   acc_cnt, mv_cnt, mv_dbl, rdy_both;
  logic mv_prev;
  logic stall;
  logic [W-1:0] mem [512];
  logic [W-1:0] exp_d [8];

  mem_arbiter #(.W(W), .AD(AD), .TMO(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i),
    .a_wr_rd_i(a_wr_rd_i), .a_valid_i(a_valid_i),
    .a_ready_o(a_ready_o), .a_rdata_o(a_rdata_o), .a_err_o(a_err_o),
    .b_addr_i(b_addr_i), .b_wdata_i(b_wdata_i),
    .b_wr_rd_i(b_wr_rd_i), .b_valid_i(b_valid_i),
    .b_ready_o(b_ready_o), .b_rdata_o(b_rdata_o), .b_err_o(b_err_o),
    .mem_addr_o(mem_addr_o), .mem_write_o(mem_write_o),
    .mem_wr_rd_o(mem_wr_rd_o), .mem_valid_o(mem_valid_o),
    .mem_ready_i(mem_ready_i), .mem_read_i(mem_read_i),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // one-cycle-latency memory; stall suppresses the response entirely
  always @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_ready_i <= 1'b0;
      mem_read_i  <= '0;
      acc_cnt     <= 0;
      mem[3]      <= 16'h0003;
      mem[7]      <= 16'h0007;
    end else begin
      mem_ready_i <= 1'b0;
      if (mem_valid_o && !stall) begin
        acc_cnt     <= acc_cnt + 1;
        mem_ready_i <= 1'b1;
        if (mem_wr_rd_o) mem[mem_addr_o] <= mem_write_o;
        else             mem_read_i <= mem[mem_addr_o];
      end
    end
  end

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      mv_cnt   <= 0;
      mv_dbl   <= 0;
      rdy_both <= 0;
      mv_prev  <= 1'b0;
    end else begin
      if (mem_valid_o) mv_cnt <= mv_cnt + 1;
      if (mem_valid_o && mv_prev) mv_dbl <= mv_dbl + 1;
      if (a_ready_o && b_ready_o) rdy_both <= rdy_both + 1;
      mv_prev <= mem_valid_o;
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // cyc counts the presentation cycle as 1
  task automatic wait_rdy(input int lim, output int cyc);
    cyc = 1;
    while (!(a_ready_o || b_ready_o) && cyc < lim) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    int c;
    int n0;
    rst_ni    = 1'b0;
    stall     = 1'b0;
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
    a_addr_i  = '0;
    b_addr_i  = '0;
    a_wdata_i = '0;
    b_wdata_i = '0;
    a_wr_rd_i = 1'b0;
    b_wr_rd_i = 1'b0;
    for (int i = 0; i < 8; i++)
      exp_d[i] = 16'(i * 257) ^ 16'hC0DE;
    step();
    step();
    chk("rst_mem_valid", 32'(mem_valid_o), 32'd0);
    chk("rst_ready", 32'({a_ready_o, b_ready_o}), 32'd0);
    chk("rst_rdata", 32'({a_rdata_o, b_rdata_o}), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    rst_ni = 1'b1;
    step();

    a_addr_i  = 9'd3;
    b_addr_i  = 9'd7;
    a_valid_i = 1'b1;
    b_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_rdy(12, c);
      chk("rr_lat", 32'(c), 32'd4);
      if (k % 2 == 0) begin
        chk("rr_grant_a", 32'({a_ready_o, b_ready_o}), 32'd2);
        chk("rr_a_rdata", 32'(a_rdata_o), 32'h0003);
      end else begin
        chk("rr_grant_b", 32'({a_ready_o, b_ready_o}), 32'd1);
        chk("rr_b_rdata", 32'(b_rdata_o), 32'h0007);
      end
      if (k == 3) begin
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
      end
      step();
    end
    chk("rr_overlap", 32'(rdy_both), 32'd0);

    b_addr_i  = 9'd3;
    b_valid_i = 1'b1;
    wait_rdy(12, c);
    chk("b_only_lat", 32'(c), 32'd4);
    chk("b_only_grant", 32'({a_ready_o, b_ready_o}), 32'd1);
    chk("b_only_rdata", 32'(b_rdata_o), 32'h0003);
    step();
    b_valid_i = 1'b0;

    n0        = mv_cnt;
    a_addr_i  = 9'h1A5;
    a_wdata_i = 16'hBEEF;
    a_wr_rd_i = 1'b1;
    a_valid_i = 1'b1;
    wait_rdy(12, c);
    chk("wr_lat", 32'(c), 32'd4);
    chk("wr_grant", 32'({a_ready_o, b_ready_o}), 32'd2);
    chk("wr_err", 32'(a_err_o), 32'd0);
    chk("wr_rdata_hold", 32'(a_rdata_o), 32'h0003);
    step();
    a_wr_rd_i = 1'b0;
    wait_rdy(12, c);
    chk("rd_lat", 32'(c), 32'd4);
    chk("rd_rdata", 32'(a_rdata_o), 32'hBEEF);
    chk("rd_err", 32'(a_err_o), 32'd0);
    step();
    a_valid_i = 1'b0;
    chk("wr_rd_pulses", 32'(mv_cnt - n0), 32'd2);

    stall     = 1'b1;
    b_addr_i  = 9'd7;
    b_wr_rd_i = 1'b0;
    b_valid_i = 1'b1;
    wait_rdy(40, c);
    chk("tmo_lat", 32'(c), 32'(TMO + 4));
    chk("tmo_grant", 32'({a_ready_o, b_ready_o}), 32'd1);
    chk("tmo_err", 32'(b_err_o), 32'd1);
    chk("tmo_rdata", 32'(b_rdata_o), 32'd0);
    chk("tmo_flag", 32'(timeout_o), 32'd1);
    step();
    b_valid_i = 1'b0;
    stall     = 1'b0;
    chk("tmo_err_clr", 32'(b_err_o), 32'd0);
    chk("tmo_sticky", 32'(timeout_o), 32'd1);
    b_valid_i = 1'b1;
    wait_rdy(12, c);
    chk("post_tmo_lat", 32'(c), 32'd4);
    chk("post_tmo_err", 32'(b_err_o), 32'd0);
    chk("post_tmo_rdata", 32'(b_rdata_o), 32'h0007);
    chk("post_tmo_sticky", 32'(timeout_o), 32'd1);
    step();
    b_valid_i = 1'b0;

    n0        = acc_cnt;
    a_wr_rd_i = 1'b1;
    a_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_addr_i  = 9'(i);
      a_wdata_i = exp_d[i];
      wait_rdy(12, c);
      chk("b2b_wr_lat", 32'(c), 32'd4);
      step();
    end
    a_wr_rd_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_addr_i = 9'(i);
      wait_rdy(12, c);
      chk("b2b_rd_lat", 32'(c), 32'd4);
      chk("b2b_rd_data", 32'(a_rdata_o), 32'(exp_d[i]));
      step();
    end
    a_valid_i = 1'b0;
    chk("b2b_accesses", 32'(acc_cnt - n0), 32'd16);
    chk("mv_consecutive", 32'(mv_dbl), 32'd0);
    chk("ready_overlap", 32'(rdy_both), 32'd0);

    stall     = 1'b1;
    a_addr_i  = 9'h1A5;
    a_wdata_i = 16'h1234;
    a_valid_i = 1'b1;
    step();
    step();
    step();
    chk("pre_rst_addr", 32'(mem_addr_o), 32'h1A5);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_mem_addr", 32'(mem_addr_o), 32'd0);
    chk("arst_mem_wdata", 32'(mem_write_o), 32'd0);
    chk("arst_mem_ctl", 32'({mem_wr_rd_o, mem_valid_o}), 32'd0);
    chk("arst_ready", 32'({a_ready_o, b_ready_o}), 32'd0);
    chk("arst_err", 32'({a_err_o, b_err_o}), 32'd0);
    chk("arst_a_rdata", 32'(a_rdata_o), 32'd0);
    chk("arst_b_rdata", 32'(b_rdata_o), 32'd0);
    chk("arst_timeout", 32'(timeout_o), 32'd0);
    a_valid_i = 1'b0;
    stall     = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
    n0     = mv_cnt;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rel_ready", 32'({a_ready_o, b_ready_o}), 32'd0);
    end
    chk("rel_mem_valid", 32'(mv_cnt - n0), 32'd0);

    a_addr_i  = 9'd3;
    b_addr_i  = 9'd7;
    a_valid_i = 1'b1;
    b_valid_i = 1'b1;
    wait_rdy(12, c);
    chk("rst_ptr_lat", 32'(c), 32'd4);
    chk("rst_ptr_grant", 32'({a_ready_o, b_ready_o}), 32'd2);
    chk("rst_ptr_rdata", 32'(a_rdata_o), 32'h0003);
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
